// File: rtl/nbbpu_pkg.sv
// Shared NBBPU definitions: RAM word/address widths, the bootloader frame
// start byte, and the state encodings used by ram_loader and uart_rx.
// Build option: LOADER_CHECKSUM_EN adds the CHECK loader state.
package nbbpu_pkg;

  localparam int unsigned WORD_WIDTH   = 16;
  localparam int unsigned ADDR_WIDTH   = 16;
  localparam logic [7:0]  LOADER_MAGIC = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    COUNT_HI,
    COUNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE,
    ERROR
`ifdef LOADER_CHECKSUM_EN
    , CHECK
`endif
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Ports: clock, reset (sync, active-high), rx (async serial line, idle high),
//        byte_data (last received byte), byte_valid (1-cycle, good stop bit),
//        frame_err (1-cycle, stop bit sampled low).
// Parameter: CLKS_PER_BIT clock cycles per bit.
module uart_rx
  import nbbpu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          meta_q, sync_q, prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid start bit: a line already back high was a glitch.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          valid_d = sync_q;
          ferr_d  = !sync_q;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/ram_loader.sv
// Serial bootloader for the NBBPU RAM. Receives MAGIC, COUNT_HI, COUNT_LO and
// COUNT big-endian 16-bit words over UART and writes them from address 0,
// holding the CPU in reset until the image is complete.
// Ports: clock, reset (sync, active-high), rx (UART line),
//        ram_write_enable/ram_address/ram_write_data (RAM write port),
//        cpu_reset (high holds CPU), busy (frame in progress),
//        done (sticky success), error (sticky abort).
// Build option: LOADER_CHECKSUM_EN expects a trailing XOR-of-data-bytes byte.
module ram_loader
  import nbbpu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 104,
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0]  MAGIC          = LOADER_MAGIC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [WORD_WIDTH-1:0] ram_write_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e END_STATE = CHECK;
`else
  localparam loader_state_e END_STATE = DONE;
`endif

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [15:0]           remaining_q, remaining_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [7:0]            csum_q, csum_d;
  logic                  active;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      remaining_q <= '0;
      tmo_q       <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      tmo_q       <= tmo_d;
      csum_q      <= csum_d;
    end
  end

  assign active = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    csum_d      = csum_q;
    tmo_d       = '0;
    if (active) tmo_d = byte_valid ? '0 : tmo_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (byte_valid && byte_data == MAGIC) begin
          state_d = COUNT_HI;
          csum_d  = '0;
        end
      end
      COUNT_HI: begin
        if (byte_valid) begin
          remaining_d[15:8] = byte_data;
          state_d           = COUNT_LO;
        end
      end
      COUNT_LO: begin
        if (byte_valid) begin
          remaining_d[7:0] = byte_data;
          addr_d           = '0;
          state_d = ({remaining_q[15:8], byte_data} == 16'd0) ? END_STATE : DATA_HI;
        end
      end
      DATA_HI: begin
        if (byte_valid) begin
          data_d[15:8] = byte_data;
          csum_d       = csum_q ^ byte_data;
          state_d      = DATA_LO;
        end
      end
      DATA_LO: begin
        if (byte_valid) begin
          data_d[7:0] = byte_data;
          csum_d      = csum_q ^ byte_data;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        // Counters advance as the strobe ends; after the last word the address
        // rests one past it (at most 65535), so it never wraps.
        addr_d      = addr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        state_d     = (remaining_q == 16'd1) ? END_STATE : DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (byte_valid) state_d = (byte_data == csum_q) ? DONE : ERROR;
      end
`endif
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase

    if (active && (frame_err || (!byte_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1))))
      state_d = ERROR;
  end

  assign ram_write_enable = (state_q == WRITE);
  assign ram_address      = addr_q;
  assign ram_write_data   = data_q;
  assign cpu_reset        = (state_q != DONE);
  assign busy             = active;
  assign done             = (state_q == DONE);
  assign error            = (state_q == ERROR);

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

  localparam int unsigned CPB = 8;
  localparam int unsigned TMO = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic        ram_write_enable;
  logic [15:0] ram_address;
  logic [15:0] ram_write_data;
  logic        cpu_reset, busy, done, error;

  ram_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO), .MAGIC(8'hA5)) dut (
    .clock            (clock),
    .reset            (reset),
    .rx               (rx),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .cpu_reset        (cpu_reset),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clock = ~clock;

  // Write monitor: logs {address, data} per strobe cycle, flags strobes
  // longer than one cycle.
  logic [31:0] wr_log[$];
  int unsigned long_strobe;
  logic        we_prev;
  always @(negedge clock) begin
    if (reset) begin
      wr_log.delete();
      long_strobe = 0;
      we_prev     = 1'b0;
    end else begin
      if (ram_write_enable) begin
        wr_log.push_back({ram_address, ram_write_data});
        if (we_prev) long_strobe++;
      end
      we_prev = ram_write_enable;
    end
  end

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(4);
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clock);
    check({tag, " rst we"},    {31'd0, ram_write_enable}, 32'd0);
    check({tag, " rst addr"},  {16'd0, ram_address},      32'd0);
    check({tag, " rst data"},  {16'd0, ram_write_data},   32'd0);
    check({tag, " rst flags"}, {28'd0, cpu_reset, busy, done, error}, 32'b1000);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop_ok;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(stop_ok ? 2 : CPB);
  endtask

  typedef struct packed {
    logic [95:0] bytes;    // frame bytes, first byte in the top bits
    logic [3:0]  nbytes;
    logic [3:0]  bad_idx;  // byte sent with stop bit 0; 15 = none
    logic [1:0]  nwr;
    logic [31:0] wr0;
    logic [31:0] wr1;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

`ifdef LOADER_CHECKSUM_EN
  localparam int NV = 6;
`else
  localparam int NV = 5;
`endif
  vec_t vecs[NV];

  task automatic send_vec(input vec_t v);
    for (int i = 0; i < int'(v.nbytes); i++)
      send_byte(v.bytes[95-8*i -: 8], !(i == int'(v.bad_idx)));
    wait_clks(40);
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    @(negedge clock);
    check({tag, " nwrites"}, wr_log.size(), {30'd0, v.nwr});
    if (v.nwr >= 1 && wr_log.size() >= 1) check({tag, " write0"}, wr_log[0], v.wr0);
    if (v.nwr >= 2 && wr_log.size() >= 2) check({tag, " write1"}, wr_log[1], v.wr1);
    check({tag, " strobe width"}, long_strobe, 32'd0);
    check({tag, " done"},      {31'd0, done},      {31'd0, v.exp_done});
    check({tag, " error"},     {31'd0, error},     {31'd0, v.exp_err});
    check({tag, " cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !v.exp_done});
    check({tag, " busy"},      {31'd0, busy},      32'd0);
  endtask

  initial begin
`ifdef LOADER_CHECKSUM_EN
    vecs[0] = '{96'hA5_00_02_12_34_AB_CD_40_00_00_00_00, 4'd8, 4'd15, 2'd2,
                32'h0000_1234, 32'h0001_ABCD, 1'b1, 1'b0};
    vecs[1] = '{96'h00_FF_5A_A5_00_01_BE_EF_51_00_00_00, 4'd9, 4'd15, 2'd1,
                32'h0000_BEEF, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{96'hA5_00_00_00_00_00_00_00_00_00_00_00, 4'd4, 4'd15, 2'd0,
                32'h0, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{96'hA5_00_01_12_34_56_78_00_00_00_00_00, 4'd7, 4'd4, 2'd0,
                32'h0, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{96'hA5_00_01_11_22_33_A5_00_01_33_44_77, 4'd12, 4'd15, 2'd1,
                32'h0000_1122, 32'h0, 1'b1, 1'b0};
    vecs[5] = '{96'hA5_00_01_12_34_00_00_00_00_00_00_00, 4'd6, 4'd15, 2'd1,
                32'h0000_1234, 32'h0, 1'b0, 1'b1};
`else
    vecs[0] = '{96'hA5_00_02_12_34_AB_CD_00_00_00_00_00, 4'd7, 4'd15, 2'd2,
                32'h0000_1234, 32'h0001_ABCD, 1'b1, 1'b0};
    vecs[1] = '{96'h00_FF_5A_A5_00_01_BE_EF_00_00_00_00, 4'd8, 4'd15, 2'd1,
                32'h0000_BEEF, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{96'hA5_00_00_00_00_00_00_00_00_00_00_00, 4'd3, 4'd15, 2'd0,
                32'h0, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{96'hA5_00_01_12_34_56_78_00_00_00_00_00, 4'd7, 4'd4, 2'd0,
                32'h0, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{96'hA5_00_01_11_22_A5_00_01_33_44_00_00, 4'd10, 4'd15, 2'd1,
                32'h0000_1122, 32'h0, 1'b1, 1'b0};
`endif

    for (int v = 0; v < NV; v++) begin
      do_reset();
      check_reset_values($sformatf("vec%0d", v));
      send_vec(vecs[v]);
      check_vec(vecs[v], $sformatf("vec%0d", v));
    end

    // Reset in the middle of a frame aborts it; no stale timeout afterwards.
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    @(negedge clock);
    check("midreset busy before", {31'd0, busy}, 32'd1);
    do_reset();
    check_reset_values("midreset");
    wait_clks(TMO + 100);
    @(negedge clock);
    check("midreset no timeout", {30'd0, busy, error}, 32'd0);

    // Timeout after a partial data word.
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    wait_clks(TMO - 100);
    @(negedge clock);
    check("timeout early error", {31'd0, error}, 32'd0);
    check("timeout early busy",  {31'd0, busy},  32'd1);
    wait_clks(200);
    @(negedge clock);
    check("timeout error",     {31'd0, error},     32'd1);
    check("timeout busy",      {31'd0, busy},      32'd0);
    check("timeout cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("timeout done",      {31'd0, done},      32'd0);
    check("timeout nwrites",   wr_log.size(),      32'd0);

    // Clean reload after the timeout.
    do_reset();
    check_reset_values("reload");
    send_vec(vecs[0]);
    check_vec(vecs[0], "reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Serial bootloader that sits directly upstream of the NBBPU data/instruction RAM and drives its write port.
- Receives a framed program image over a UART line and writes it as 16-bit words to RAM starting at address 0.
- Holds the CPU in reset until the image is fully written, then releases it.
- Owns the RAM write port only while loading; the top level muxes the port back to the CPU once cpu_reset is low.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200).
- TIMEOUT_CYCLES, 1200000, maximum idle cycles between bytes once a frame has started (100 ms).
- MAGIC, 8'hA5, frame start byte.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- rx  input  1  UART receive line, idle high, asynchronous to clock
- ram_write_enable  output  1  one-cycle write strobe to RAM
- ram_address  output  16  RAM word address
- ram_write_data  output  16  RAM write word
- cpu_reset  output  1  high holds the CPU in reset
- busy  output  1  high while a frame is in progress
- done  output  1  sticky; image loaded successfully
- error  output  1  sticky; frame aborted

Behaviour:
- Reset values: ram_write_enable=0, ram_address=0, ram_write_data=0, cpu_reset=1, busy=0, done=0, error=0, state=IDLE. Reset mid-frame aborts immediately; partially written RAM contents are don't-care.
- Frame format: MAGIC, COUNT_HI, COUNT_LO, then COUNT words sent high byte first. COUNT ranges 0..65535.
- UART RX sub-module:
  - rx passes through a 2-flop synchroniser.
  - A falling edge starts a bit; the start bit is re-sampled at CLKS_PER_BIT/2 and the bit is discarded if rx is high (glitch).
  - 8 data bits are sampled LSB first, each at mid-bit.
  - The stop bit is sampled at mid-bit, which produces a one-cycle byte_valid (stop=1) or frame_err (stop=0).
- States: IDLE, COUNT_HI, COUNT_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR.
  - IDLE: a byte equal to MAGIC goes to COUNT_HI and sets busy=1. Other bytes and frame_err are ignored.
  - COUNT_HI then COUNT_LO latch the 16-bit count. If count=0, go to DONE; otherwise go to DATA_HI with ram_address=0.
  - DATA_HI latches the high byte. DATA_LO latches the low byte and then goes to WRITE.
  - WRITE: ram_write_enable=1 for exactly one cycle, with ram_address and ram_write_data stable that cycle. The write strobe is asserted the cycle after the low byte's byte_valid.
    - Next cycle: ram_address increments and remaining is decremented.
    - If remaining hits 0, go to DONE; otherwise go to DATA_HI.
  - DONE: done=1, busy=0, cpu_reset=0. Sticky until reset; all further rx is ignored.
  - ERROR: error=1, busy=0, cpu_reset stays 1. Sticky until reset.
- Errors, in any state other than IDLE, DONE or ERROR:
  - frame_err goes to ERROR.
  - The timeout counter counts cycles since the last byte_valid; reaching TIMEOUT_CYCLES goes to ERROR.
- ram_address maximum is 65534 (count=65535); the address never wraps.
- A byte arriving during WRITE cannot occur, since WRITE lasts one cycle and bytes are at least 10 bit-times apart. No buffering is required.
- ram_write_enable is never asserted outside WRITE.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined:
  - The frame carries a trailing checksum byte equal to the XOR of all data bytes; header bytes are excluded.
  - A CHECK state is added after the last WRITE, or directly after COUNT_LO when count=0.
  - Match goes to DONE; mismatch goes to ERROR.
  - The timeout also applies while waiting for the checksum byte.
- When undefined: no checksum byte, no CHECK state, and DONE follows the last WRITE directly.

Decomposition:
- Shared package nbbpu_pkg:
  - loader state enum.
  - LOADER_MAGIC constant.
  - WORD_WIDTH=16 and ADDR_WIDTH=16 constants, shared with ram.
- One sub-module: uart_rx. Ports: clock, reset, rx, byte_data[7:0], byte_valid, frame_err. Parameter: CLKS_PER_BIT.
- The frame FSM, address counter, remaining counter and timeout counter stay in ram_loader.

Test Plan:
- Basic load: send A5 00 02 12 34 AB CD. Expect writes (0, 0x1234) then (1, 0xABCD), each a single-cycle strobe. Then done=1 and cpu_reset=0. With the checksum build, append 0x40 (12^34^AB^CD).
- Preamble junk: send 00 FF 5A before A5 00 01 BE EF. Expect the junk ignored, one write (0, 0xBEEF), and done=1.
- Zero count: send A5 00 00. Expect no write strobe and done=1 (checksum build: then send 00 and expect done=1).
- Framing error: send a stop bit=0 on the second data byte of A5 00 01 xx. Expect error=1, cpu_reset=1, no write, and later bytes ignored.
- Timeout: send A5 00 01 12, then idle for TIMEOUT_CYCLES. Expect error=1 and no write. Reset must return all outputs to their reset values and allow a clean reload.
- Checksum mismatch (LOADER_CHECKSUM_EN): send A5 00 01 12 34 then 00. Expect the write (0, 0x1234) to occur, then error=1 and done=0.
